// File: rtl/edge_log_pkg.sv
// Shared constants and entry type for the edge event logger.
// Optional drop counter is enabled by EDGE_LOG_DROP_CNT_EN.
package edge_log_pkg;

    localparam int EL_W       = 8;
    localparam int EL_DEPTH   = 4;
    localparam int EL_TS_W    = 16;
    localparam int DROP_CNT_W = 16;

    typedef struct packed {
        logic [EL_TS_W-1:0] ts;
        logic [EL_W-1:0]    edges;
    } edge_entry_t;

endpackage

// File: rtl/edge_log_fifo.sv
// Synchronous show-ahead FIFO of edge_entry_t.
// Head reads as zero when empty; push on full is accepted only with a pop.
module edge_log_fifo
    import edge_log_pkg::*;
#(
    parameter int  DEPTH = EL_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  edge_entry_t din,
    input  logic        pop,
    output edge_entry_t dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    edge_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/edge_event_logger.sv
// Timestamps non-zero edge vectors into a FIFO drained over valid/ready.
// EDGE_LOG_DROP_CNT_EN adds a saturating drop counter output.
module edge_event_logger
    import edge_log_pkg::*;
#(
    parameter int  W     = EL_W,
    parameter int  DEPTH = EL_DEPTH,
    parameter int  TS_W  = EL_TS_W,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [W-1:0]    anyedge,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_edges,
    output logic [TS_W-1:0] out_ts,
    output logic [LW-1:0]   level,
    output logic            overflow,
    input  logic            clr_overflow
`ifdef EDGE_LOG_DROP_CNT_EN
   ,output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    logic [TS_W-1:0] ts;
    logic            push_req;
    logic            pop;
    logic            full;
    logic            empty;
    logic            drop;
    edge_entry_t     entry_in;
    edge_entry_t     head;

    assign push_req       = |anyedge;
    assign pop            = out_valid && out_ready;
    assign drop           = push_req && full && !pop;
    assign entry_in.ts    = ts;
    assign entry_in.edges = anyedge;
    assign out_valid      = !empty;
    assign out_edges      = head.edges;
    assign out_ts         = head.ts;

    edge_log_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (entry_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef EDGE_LOG_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop && clr_overflow) begin
            drop_cnt <= DROP_CNT_W'(1);
        end else if (drop) begin
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end else if (clr_overflow) begin
            drop_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_edge_event_logger.sv
// Directed self-checking bench for edge_event_logger.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_edge_event_logger;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  anyedge = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_edges;
    logic [15:0] out_ts;
    logic [2:0]  level;
    logic        overflow;
    logic        clr_overflow = 1'b0;
`ifdef EDGE_LOG_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int tests = 0;
    int fails = 0;

    edge_event_logger dut (
        .clk          (clk),
        .reset        (reset),
        .anyedge      (anyedge),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_edges    (out_edges),
        .out_ts       (out_ts),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
`ifdef EDGE_LOG_DROP_CNT_EN
       ,.drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        anyedge      = '0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        reset        = 1'b1;
        step();
        reset        = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags got v=%0b l=%0d o=%0b want 0 0 0",
                     out_valid, level, overflow);
        end
        tests++;
        if (out_edges !== 8'h00 || out_ts !== 16'h0000) begin
            fails++;
            $display("FAIL reset_data got e=%h ts=%0d want 00 0",
                     out_edges, out_ts);
        end
`ifdef EDGE_LOG_DROP_CNT_EN
        tests++;
        if (drop_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt);
        end
`endif
    endtask

    task automatic test_single_event();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tests++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            fails++;
            $display("FAIL empty_pop got v=%0b l=%0d want 0 0", out_valid, level);
        end
        anyedge = 8'h01;
        step();
        anyedge = 8'h00;
        tests++;
        if (out_valid !== 1'b1 || out_edges !== 8'h01 || out_ts !== 16'd3) begin
            fails++;
            $display("FAIL single_head got v=%0b e=%h ts=%0d want 1 01 3",
                     out_valid, out_edges, out_ts);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || out_edges !== 8'h00 || out_ts !== 16'd0) begin
            fails++;
            $display("FAIL single_drained got v=%0b e=%h ts=%0d want 0 00 0",
                     out_valid, out_edges, out_ts);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            anyedge = (c == 5) ? 8'h06 : (c == 7) ? 8'h80 : 8'h00;
            step();
        end
        anyedge = 8'h00;
        tests++;
        if (level !== 3'd2 || out_edges !== 8'h06 || out_ts !== 16'd5) begin
            fails++;
            $display("FAIL bp_hold got l=%0d e=%h ts=%0d want 2 06 5",
                     level, out_edges, out_ts);
        end
        out_ready = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b1 || out_edges !== 8'h80 || out_ts !== 16'd7) begin
            fails++;
            $display("FAIL bp_second got v=%0b e=%h ts=%0d want 1 80 7",
                     out_valid, out_edges, out_ts);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            fails++;
            $display("FAIL bp_empty got v=%0b l=%0d want 0 0", out_valid, level);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            anyedge = 8'(c + 1);
            step();
        end
        anyedge = 8'h00;
        tests++;
        if (level !== 3'd4 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_state got l=%0d o=%0b want 4 1", level, overflow);
        end
`ifdef EDGE_LOG_DROP_CNT_EN
        tests++;
        if (drop_cnt !== 16'd1) begin
            fails++;
            $display("FAIL ovf_drop_cnt got %0d want 1", drop_cnt);
        end
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (out_edges !== 8'(k + 1) || out_ts !== 16'(k)) begin
                fails++;
                $display("FAIL ovf_drain%0d got e=%h ts=%0d want %h %0d",
                         k, out_edges, out_ts, 8'(k + 1), k);
            end
            step();
        end
        tests++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_after got v=%0b o=%0b want 0 1", out_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_e [4];
        logic [15:0] exp_t [4];
        exp_e[0] = 8'h22; exp_e[1] = 8'h33; exp_e[2] = 8'h44; exp_e[3] = 8'hAA;
        exp_t[0] = 16'd1; exp_t[1] = 16'd2; exp_t[2] = 16'd3; exp_t[3] = 16'd4;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            anyedge = 8'h11 * 8'(c + 1);
            step();
        end
        anyedge   = 8'hAA;
        out_ready = 1'b1;
        step();
        anyedge = 8'h00;
        tests++;
        if (level !== 3'd4 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL fpp_state got l=%0d o=%0b want 4 0", level, overflow);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (out_edges !== exp_e[k] || out_ts !== exp_t[k]) begin
                fails++;
                $display("FAIL fpp_drain%0d got e=%h ts=%0d want %h %0d",
                         k, out_edges, out_ts, exp_e[k], exp_t[k]);
            end
            step();
        end
    endtask

    task automatic test_clear_vs_drop();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            anyedge = 8'h10 + 8'(c);
            step();
        end
        anyedge      = 8'h77;
        clr_overflow = 1'b1;
        step();
        tests++;
        if (overflow !== 1'b1 || level !== 3'd4) begin
            fails++;
            $display("FAIL clr_drop got o=%0b l=%0d want 1 4", overflow, level);
        end
`ifdef EDGE_LOG_DROP_CNT_EN
        tests++;
        if (drop_cnt !== 16'd1) begin
            fails++;
            $display("FAIL clr_drop_cnt got %0d want 1", drop_cnt);
        end
`endif
        anyedge = 8'h00;
        step();
        clr_overflow = 1'b0;
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL clr_only got o=%0b want 0", overflow);
        end
`ifdef EDGE_LOG_DROP_CNT_EN
        tests++;
        if (drop_cnt !== 16'd0) begin
            fails++;
            $display("FAIL clr_only_cnt got %0d want 0", drop_cnt);
        end
`endif
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            anyedge = 8'h31 + 8'(c);
            step();
        end
        anyedge = 8'h00;
        tests++;
        if (level !== 3'd3) begin
            fails++;
            $display("FAIL mr_fill got l=%0d want 3", level);
        end
        reset   = 1'b1;
        anyedge = 8'h99;
        step();
        reset = 1'b0;
        tests++;
        if (level !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0 ||
            out_edges !== 8'h00) begin
            fails++;
            $display("FAIL mr_cleared got l=%0d v=%0b o=%0b e=%h want 0 0 0 00",
                     level, out_valid, overflow, out_edges);
        end
        anyedge = 8'h5A;
        step();
        anyedge = 8'h00;
        tests++;
        if (level !== 3'd1 || out_edges !== 8'h5A || out_ts !== 16'd0) begin
            fails++;
            $display("FAIL mr_first got l=%0d e=%h ts=%0d want 1 5A 0",
                     level, out_edges, out_ts);
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_clear_vs_drop();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/edge_event_logger.md
Name: edge_event_logger

Overview:
- Downstream consumer of the registered any-edge detector stage.
- Takes the per-bit edge vector every cycle.
- For each cycle with a non-zero vector, records {timestamp, edge vector} into a small FIFO.
- Presents FIFO entries to a reader over a valid/ready handshake, so bursts of edge events can be drained later without loss until the FIFO fills.

Parameters:
- W, 8, width of the edge vector (matches the detector's 8-bit output).
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- TS_W, 16, timestamp counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- anyedge  in  W  edge vector from the detector; sampled every rising clk.
- out_valid  out  1  head entry available.
- out_ready  in  1  reader accepts head entry.
- out_edges  out  W  edge vector of head entry.
- out_ts  out  TS_W  timestamp of head entry.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one event was dropped.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Reset (one clk with reset=1):
  - ts counter = 0, FIFO emptied, level = 0, out_valid = 0, out_edges = 0, out_ts = 0, overflow = 0.
  - Reset asserted mid-operation discards all stored entries immediately; no partial pop.
- Timestamp:
  - Free-running TS_W-bit counter; increments on every non-reset clk.
  - Wraps from 2^TS_W-1 to 0 with no flag.
  - The first non-reset cycle carries ts = 0.
- Push:
  - Condition: anyedge != 0 at a rising edge.
  - Entry stored: {ts value during that cycle, anyedge}.
  - anyedge == 0 never pushes.
- Pop: out_valid && out_ready at a rising edge removes the head entry.
- Output path:
  - Show-ahead; out_valid = (level != 0).
  - out_edges and out_ts come from registered storage, with no combinational path from anyedge.
  - Both read as 0 when out_valid = 0.
  - An event pushed at edge N is visible on the outputs after edge N, i.e. one cycle of latency.
  - Outputs are stable while out_valid && !out_ready.
- Full with push:
  - Pop in the same cycle: push is accepted and level is unchanged.
  - No pop: event dropped, FIFO unchanged, overflow set.
- Empty with pop attempt: ignored, since out_valid = 0.
- Push and pop on a non-empty, non-full FIFO: level unchanged, head advances.
- Overflow clear: clr_overflow clears overflow. If a drop occurs in the same cycle, set wins.
- Pointers: read and write pointers wrap modulo DEPTH. Level is held in a separate counter or an extra pointer bit, so full and empty are distinguishable.

Optional Feature:
- Macro: EDGE_LOG_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt (16 bits): count of dropped events, saturating at 16'hFFFF.
  - Reset to 0.
  - Cleared by clr_overflow, unless a drop occurs the same cycle, in which case it is set to 1.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package edge_log_pkg holds:
  - Default constants for W, DEPTH and TS_W.
  - Packed struct typedef edge_entry_t {ts, edges}.
- Sub-module edge_log_fifo:
  - Generic synchronous show-ahead FIFO of edge_entry_t.
  - Exposes push, pop, full, empty and level.
- Top level holds the timestamp counter, push qualification, overflow and drop logic.

Test Plan:
- Single event:
  - Stimulus: deassert reset; anyedge = 0 for cycles 0-2; anyedge = 8'h01 in cycle 3; out_ready = 1.
  - Response: after cycle 3, out_valid = 1, out_edges = 8'h01, out_ts = 3; one cycle later, out_valid = 0 and outputs read 0.
- Backpressure:
  - Stimulus: out_ready = 0; events 8'h06 in cycle 5 and 8'h80 in cycle 7.
  - Response: level reaches 2; head holds {5, 8'h06} stable; raising out_ready yields {5, 8'h06} then {7, 8'h80}.
- Overflow:
  - Stimulus: out_ready = 0; 5 consecutive non-zero vectors 8'h01 to 8'h05 with DEPTH = 4.
  - Response: level = 4, overflow = 1; the 8'h05 event is dropped; drain order is 01, 02, 03, 04. With the macro, drop_cnt = 1.
- Full with simultaneous pop and push:
  - Stimulus: FIFO full; out_ready = 1 and anyedge = 8'hAA in the same cycle.
  - Response: level stays 4, overflow stays 0, and 8'hAA drains last.
- Overflow clear versus drop:
  - Stimulus: overflow = 1; assert clr_overflow in a cycle with a full FIFO and another drop.
  - Response: overflow remains 1; a later clr_overflow with no drop clears it to 0.
- Mid-operation reset:
  - Stimulus: 3 entries stored; assert reset for one cycle.
  - Response: level = 0, out_valid = 0, overflow = 0; the next event at the first post-reset cycle carries ts = 0.
